// File: rtl/pio_pinmux_ctrl.sv
// pio_pinmux_ctrl
// Registered per-pin function multiplexer for PIO banks with bus-turnaround
// guard on function switch, 2-flop input synchronisers and maskable
// edge-interrupt capture. The top level keeps only the tristate buffers:
// pin = oPIN_OE ? oPIN_OUT : 'z.
//
// Optional feature macro: PIO_PINMUX_FILTER_EN
//   When defined, adds parameter FILT_LEN and a per-pin stability filter
//   after the synchroniser. oPIN_IN_SYNC and edge detection then use the
//   filtered value, giving 2+FILT_LEN cycles of input latency.
//
// Ports:
//   iCLK          block clock
//   iRESET        synchronous active-high reset
//   iMSEL         requested function per pin, SELW bits each
//   iPIO_OUT      function-0 output data
//   iPIO_DIR      function-0 direction, 1 = drive
//   iALT_OUT      alternate outputs, function f pin i at (f-1)*N_PINS+i
//   iALT_OE       alternate output enables, same packing
//   iPIN_IN       raw asynchronous pad inputs
//   iIRQ_RISE_MSK rising edge sets pending
//   iIRQ_FALL_MSK falling edge sets pending
//   iIRQ_CLR      single-cycle clear strobe per pin
//   oPIN_OUT      registered pad data
//   oPIN_OE       registered pad output enable
//   oPIN_IN_SYNC  synchronised (optionally filtered) pad input
//   oIRQ_PEND     sticky per-pin pending flags
//   oIRQ          registered OR of oIRQ_PEND
module pio_pinmux_ctrl #(
  parameter int N_PINS    = 32,
  parameter int N_FUNC    = 4,
  parameter int SELW      = 2,
  parameter int GUARD_CYC = 2
`ifdef PIO_PINMUX_FILTER_EN
  ,
  parameter int FILT_LEN  = 4
`endif
) (
  input  logic                         iCLK,
  input  logic                         iRESET,
  input  logic [N_PINS*SELW-1:0]       iMSEL,
  input  logic [N_PINS-1:0]            iPIO_OUT,
  input  logic [N_PINS-1:0]            iPIO_DIR,
  input  logic [N_PINS*(N_FUNC-1)-1:0] iALT_OUT,
  input  logic [N_PINS*(N_FUNC-1)-1:0] iALT_OE,
  input  logic [N_PINS-1:0]            iPIN_IN,
  input  logic [N_PINS-1:0]            iIRQ_RISE_MSK,
  input  logic [N_PINS-1:0]            iIRQ_FALL_MSK,
  input  logic [N_PINS-1:0]            iIRQ_CLR,
  output logic [N_PINS-1:0]            oPIN_OUT,
  output logic [N_PINS-1:0]            oPIN_OE,
  output logic [N_PINS-1:0]            oPIN_IN_SYNC,
  output logic [N_PINS-1:0]            oIRQ_PEND,
  output logic                         oIRQ
);

  typedef enum logic {ST_ACTIVE, ST_GUARD} state_t;

  localparam logic [3:0] GUARD_RELOAD = 4'(GUARD_CYC - 1);

  // Output select path
  state_t          r_state   [N_PINS];
  state_t          w_state_nx[N_PINS];
  logic [SELW-1:0] r_sel     [N_PINS];
  logic [SELW-1:0] w_sel_nx  [N_PINS];
  logic [SELW-1:0] r_next    [N_PINS];
  logic [SELW-1:0] w_next_nx [N_PINS];
  logic [3:0]      r_cnt     [N_PINS];
  logic [3:0]      w_cnt_nx  [N_PINS];
  logic [N_PINS-1:0] w_oe_nx, w_out_nx;
  logic [N_PINS-1:0] r_oe, r_out;

  // Input path
  logic [N_PINS-1:0] r_s1, r_s2, r_s3;
  logic [N_PINS-1:0] w_in_q;
  logic [N_PINS-1:0] w_rise, w_fall, w_set;
  logic [N_PINS-1:0] r_pend;
  logic              r_irq;

  // Per-pin ACTIVE/GUARD next-state
  always_comb begin
    for (int unsigned i = 0; i < N_PINS; i++) begin
      logic [SELW-1:0] w_req;
      w_req         = iMSEL[i*SELW +: SELW];
      w_state_nx[i] = r_state[i];
      w_sel_nx[i]   = r_sel[i];
      w_next_nx[i]  = r_next[i];
      w_cnt_nx[i]   = r_cnt[i];
      case (r_state[i])
        ST_ACTIVE: begin
          if (w_req != r_sel[i]) begin
            if (GUARD_CYC == 0) begin
              w_sel_nx[i] = w_req;
            end else begin
              w_state_nx[i] = ST_GUARD;
              w_next_nx[i]  = w_req;
              w_cnt_nx[i]   = GUARD_RELOAD;
            end
          end
        end
        ST_GUARD: begin
          if (w_req != r_next[i]) begin
            // A moving request restarts the full turnaround window.
            w_next_nx[i] = w_req;
            w_cnt_nx[i]  = GUARD_RELOAD;
          end else if (r_cnt[i] == 4'd0) begin
            w_sel_nx[i]   = r_next[i];
            w_state_nx[i] = ST_ACTIVE;
          end else begin
            w_cnt_nx[i] = r_cnt[i] - 4'd1;
          end
        end
        default: begin
          w_state_nx[i] = ST_ACTIVE;
        end
      endcase
    end
  end

  // Output mux; selects at or above N_FUNC fall through to tristate.
  always_comb begin
    w_oe_nx  = '0;
    w_out_nx = '0;
    for (int unsigned i = 0; i < N_PINS; i++) begin
      if (r_state[i] == ST_ACTIVE) begin
        if (r_sel[i] == '0) begin
          w_oe_nx[i]  = iPIO_DIR[i];
          w_out_nx[i] = iPIO_OUT[i];
        end else begin
          for (int unsigned f = 1; f < N_FUNC; f++) begin
            if (r_sel[i] == SELW'(f)) begin
              w_oe_nx[i]  = iALT_OE[(f-1)*N_PINS + i];
              w_out_nx[i] = iALT_OUT[(f-1)*N_PINS + i];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      for (int unsigned i = 0; i < N_PINS; i++) begin
        r_state[i] <= ST_ACTIVE;
        r_sel[i]   <= '0;
        r_next[i]  <= '0;
        r_cnt[i]   <= '0;
      end
      r_oe  <= '0;
      r_out <= '0;
    end else begin
      for (int unsigned i = 0; i < N_PINS; i++) begin
        r_state[i] <= w_state_nx[i];
        r_sel[i]   <= w_sel_nx[i];
        r_next[i]  <= w_next_nx[i];
        r_cnt[i]   <= w_cnt_nx[i];
      end
      r_oe  <= w_oe_nx;
      r_out <= w_out_nx;
    end
  end

  // Two-flop synchroniser
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= iPIN_IN;
      r_s2 <= r_s1;
    end
  end

`ifdef PIO_PINMUX_FILTER_EN
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [FCW-1:0]    r_fcnt[N_PINS];
  logic [N_PINS-1:0] r_filt;

  // Filtered value follows s2 only after FILT_LEN consecutive differing samples.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      for (int unsigned i = 0; i < N_PINS; i++) r_fcnt[i] <= '0;
      r_filt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_PINS; i++) begin
        if (r_s2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FCW'(FILT_LEN - 1)) begin
          r_filt[i] <= r_s2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_in_q = r_filt;
`else
  assign w_in_q = r_s2;
`endif

  assign w_rise = w_in_q & ~r_s3;
  assign w_fall = ~w_in_q & r_s3;
  assign w_set  = (w_rise & iIRQ_RISE_MSK) | (w_fall & iIRQ_FALL_MSK);

  // Edge history, sticky pending (set beats clear), registered summary IRQ
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_s3   <= '0;
      r_pend <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_s3   <= w_in_q;
      r_pend <= (r_pend & ~iIRQ_CLR) | w_set;
      r_irq  <= |r_pend;
    end
  end

  assign oPIN_OUT     = r_out;
  assign oPIN_OE      = r_oe;
  assign oPIN_IN_SYNC = w_in_q;
  assign oIRQ_PEND    = r_pend;
  assign oIRQ         = r_irq;

endmodule

// File: tb/tb_pio_pinmux_ctrl.sv
module tb_pio_pinmux_ctrl;

`ifdef PIO_PINMUX_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif

  localparam int SIG_OE = 0, SIG_OUT = 1, SIG_SYNC = 2, SIG_PEND = 3, SIG_IRQ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] msel;
  logic [3:0] pio_out, pio_dir;
  logic [7:0] alt_out, alt_oe;
  logic [3:0] pin_in, rmsk, fmsk, clr;
  logic [3:0] pin_out, pin_oe, pin_sync, pend;
  logic       irq;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] mask;
    logic [3:0] val;
  } exp_t;

  exp_t q[$];

  pio_pinmux_ctrl #(
    .N_PINS(4), .N_FUNC(3), .SELW(2), .GUARD_CYC(2)
`ifdef PIO_PINMUX_FILTER_EN
    , .FILT_LEN(4)
`endif
  ) dut (
    .iCLK(clk), .iRESET(rst), .iMSEL(msel),
    .iPIO_OUT(pio_out), .iPIO_DIR(pio_dir),
    .iALT_OUT(alt_out), .iALT_OE(alt_oe),
    .iPIN_IN(pin_in), .iIRQ_RISE_MSK(rmsk), .iIRQ_FALL_MSK(fmsk),
    .iIRQ_CLR(clr),
    .oPIN_OUT(pin_out), .oPIN_OE(pin_oe), .oPIN_IN_SYNC(pin_sync),
    .oIRQ_PEND(pend), .oIRQ(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int d, int s, logic [3:0] m, logic [3:0] v);
    exp_t e;
    int   k;
    e.cyc = cyc + d; e.sig = s; e.mask = m; e.val = v;
    k = q.size();
    while (k > 0 && q[k-1].cyc > e.cyc) k--;
    q.insert(k, e);
  endfunction

  function automatic string sig_name(int s);
    case (s)
      SIG_OE:   return "oPIN_OE";
      SIG_OUT:  return "oPIN_OUT";
      SIG_SYNC: return "oPIN_IN_SYNC";
      SIG_PEND: return "oIRQ_PEND";
      default:  return "oIRQ";
    endcase
  endfunction

  function automatic logic [3:0] sample(int s);
    case (s)
      SIG_OE:   return pin_oe;
      SIG_OUT:  return pin_out;
      SIG_SYNC: return pin_sync;
      SIG_PEND: return pend;
      default:  return {3'b000, irq};
    endcase
  endfunction

  exp_t       m_e;
  logic [3:0] m_act;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e   = q.pop_front();
      m_act = sample(m_e.sig) & m_e.mask;
      checks++;
      if (m_e.cyc != cyc || m_act !== m_e.val) begin
        failures++;
        $display("FAIL %s due_cyc=%0d at_cyc=%0d mask=%h actual=%h expected=%h",
                 sig_name(m_e.sig), m_e.cyc, cyc, m_e.mask, m_act, m_e.val);
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst     = 1'b1;
    msel    = '0;
    pio_out = 4'hA;
    pio_dir = 4'hF;
    alt_oe  = 8'hEC;
    alt_out = 8'hE4;
    pin_in  = '0;
    rmsk    = '0;
    fmsk    = '0;
    clr     = '0;

    push(1, SIG_OE, 4'hF, 4'h0);
    push(1, SIG_OUT, 4'hF, 4'h0);
    push(1, SIG_SYNC, 4'hF, 4'h0);
    push(2, SIG_PEND, 4'hF, 4'h0);
    push(2, SIG_IRQ, 4'h1, 4'h0);
    step(3);
    checks++;
    if (pin_oe !== 4'h0) begin
      failures++;
      $display("FAIL direct oPIN_OE in reset actual=%h expected=0", pin_oe);
    end

    rst = 1'b0;
    push(0, SIG_OE, 4'hF, 4'h0);
    push(1, SIG_OE, 4'hF, 4'hF);
    push(1, SIG_OUT, 4'hF, 4'hA);
    push(1, SIG_PEND, 4'hF, 4'h0);
    push(1, SIG_IRQ, 4'h1, 4'h0);
    step(3);
    checks++;
    if (pin_oe !== 4'hF) begin
      failures++;
      $display("FAIL direct oPIN_OE after release actual=%h expected=F", pin_oe);
    end
    checks++;
    if (pin_out !== 4'hA) begin
      failures++;
      $display("FAIL direct oPIN_OUT after release actual=%h expected=A", pin_out);
    end

    msel[3:2] = 2'd2;
    push(1, SIG_OE, 4'h2, 4'h2);
    push(2, SIG_OE, 4'h2, 4'h0);
    push(2, SIG_OUT, 4'h2, 4'h0);
    push(2, SIG_OE, 4'hD, 4'hD);
    push(3, SIG_OE, 4'h2, 4'h0);
    push(3, SIG_OUT, 4'hD, 4'h8);
    push(4, SIG_OE, 4'h2, 4'h2);
    push(4, SIG_OUT, 4'h2, 4'h2);
    step(6);

    msel[7:6] = 2'd2;
    push(2, SIG_OE, 4'h8, 4'h0);
    push(2, SIG_OUT, 4'h8, 4'h0);
    push(3, SIG_OE, 4'h8, 4'h0);
    push(3, SIG_OUT, 4'h8, 4'h0);
    push(4, SIG_OE, 4'h8, 4'h0);
    push(4, SIG_OUT, 4'h8, 4'h0);
    push(5, SIG_OE, 4'h8, 4'h8);
    push(5, SIG_OUT, 4'h8, 4'h0);
    step(1);
    msel[7:6] = 2'd1;
    step(6);

    msel[5:4] = 2'd3;
    push(1, SIG_OE, 4'h4, 4'h4);
    for (int d = 2; d <= 7; d++) begin
      push(d, SIG_OE, 4'h4, 4'h0);
      push(d, SIG_OUT, 4'h4, 4'h0);
    end
    step(9);
    checks++;
    if (pin_oe[2] !== 1'b0) begin
      failures++;
      $display("FAIL direct oPIN_OE[2] illegal select actual=%b expected=0", pin_oe[2]);
    end
    checks++;
    if (pin_out[2] !== 1'b0) begin
      failures++;
      $display("FAIL direct oPIN_OUT[2] illegal select actual=%b expected=0", pin_out[2]);
    end

    rmsk = 4'h1;
    fmsk = 4'h0;
    pin_in[0] = 1'b1;
    push(1 + LAT, SIG_SYNC, 4'h1, 4'h0);
    push(2 + LAT, SIG_SYNC, 4'h1, 4'h1);
    push(2 + LAT, SIG_PEND, 4'h1, 4'h0);
    push(3 + LAT, SIG_PEND, 4'h1, 4'h1);
    push(3 + LAT, SIG_IRQ, 4'h1, 4'h0);
    push(4 + LAT, SIG_IRQ, 4'h1, 4'h1);
    step(6 + LAT);

    clr[0] = 1'b1;
    push(1, SIG_PEND, 4'h1, 4'h0);
    push(2, SIG_IRQ, 4'h1, 4'h0);
    step(1);
    clr[0] = 1'b0;
    step(3);

    pin_in[0] = 1'b0;
    push(3 + LAT, SIG_PEND, 4'h1, 4'h0);
    push(5 + LAT, SIG_PEND, 4'h1, 4'h0);
    push(5 + LAT, SIG_IRQ, 4'h1, 4'h0);
    step(6 + LAT);

    pin_in[0] = 1'b1;
    step(2 + LAT);
    clr[0] = 1'b1;
    push(0, SIG_PEND, 4'h1, 4'h0);
    push(1, SIG_PEND, 4'h1, 4'h1);
    step(1);
    clr[0] = 1'b0;
    push(1, SIG_IRQ, 4'h1, 4'h1);
    step(2);

    rmsk = 4'h0;
    push(2, SIG_PEND, 4'h1, 4'h1);
    step(4);
    checks++;
    if (pend[0] !== 1'b1) begin
      failures++;
      $display("FAIL direct oIRQ_PEND[0] after mask drop actual=%b expected=1", pend[0]);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL direct oIRQ after mask drop actual=%b expected=1", irq);
    end

`ifdef PIO_PINMUX_FILTER_EN
    rmsk = 4'h2;
    pin_in[1] = 1'b1;
    for (int d = 1; d <= 10; d++) push(d, SIG_SYNC, 4'h2, 4'h0);
    push(10, SIG_PEND, 4'h2, 4'h0);
    step(3);
    pin_in[1] = 1'b0;
    step(10);

    pin_in[1] = 1'b1;
    push(5, SIG_SYNC, 4'h2, 4'h0);
    push(6, SIG_SYNC, 4'h2, 4'h2);
    push(6, SIG_PEND, 4'h2, 4'h0);
    push(7, SIG_PEND, 4'h2, 4'h2);
    step(5);
    pin_in[1] = 1'b0;
    step(10);
`endif

    for (int w = 0; w < 20 && q.size() > 0; w++) step(1);
    while (q.size() > 0) begin
      m_e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s due_cyc=%0d never_checked actual=none expected=%h",
               sig_name(m_e.sig), m_e.cyc, m_e.val);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
